// File: rtl/bubsys_cpubus_pkg.sv
// bubsys_cpubus_pkg: shared FSM states, chip-select indices and idle data value for the CPU-bus initiator
package bubsys_cpubus_pkg;
   typedef enum logic [2:0] {IDLE, ADDR, STRB, WAIT, LATCH, END} state_t;
   localparam logic [2:0] CS_VZ  = 3'd0;
   localparam logic [2:0] CS_V1  = 3'd1;
   localparam logic [2:0] CS_V2  = 3'd2;
   localparam logic [2:0] CS_CHA = 3'd3;
   localparam logic [2:0] CS_OBJ = 3'd4;
   localparam logic [15:0] IDLE_DOUT_DEF = 16'hFFFF;
endpackage

// File: rtl/bubsys_cpubus_initiator.sv
// bubsys_cpubus_initiator: 68000-style bus-cycle master paced by the 9 MHz enable; BUBSYS_CPUBUS_TIMEOUT_EN adds a WAIT timeout
module bubsys_cpubus_initiator
   import bubsys_cpubus_pkg::*;
#(
   parameter int          TIMEOUT_TICKS = 32,
   parameter logic [15:0] IDLE_DOUT     = IDLE_DOUT_DEF
)(
   input  logic        i_EMU_MCLK,
   input  logic        i_EMU_MRST,
   input  logic        i_EMU_CLK9MPCEN_n,
   input  logic        i_CMD_VALID,
   output logic        o_CMD_READY,
   input  logic        i_CMD_RW,
   input  logic [14:0] i_CMD_ADDR,
   input  logic [15:0] i_CMD_WDATA,
   input  logic [1:0]  i_CMD_BE,
   input  logic [2:0]  i_CMD_CS,
   output logic [14:0] o_CPU_ADDR,
   output logic [15:0] o_CPU_DOUT,
   output logic        o_CPU_RW,
   output logic        o_CPU_UDS_n,
   output logic        o_CPU_LDS_n,
   output logic        o_VZCS_n,
   output logic        o_VCS1_n,
   output logic        o_VCS2_n,
   output logic        o_CHACS_n,
   output logic        o_OBJRAM_n,
   input  logic [15:0] i_CPU_DIN,
   input  logic        i_DTACK_n,
   output logic        o_RSP_VALID,
   output logic [15:0] o_RSP_RDATA,
   output logic        o_RSP_ERR
);
   state_t      state, state_nx;
   logic        tick, accept, act, strb, timeout;
   logic        rw_q, valid_q, err_q;
   logic [14:0] addr_q;
   logic [15:0] wdata_q, rdata_q;
   logic [1:0]  be_q;
   logic [2:0]  cs_q;

   // one-hot chip select; indices beyond OBJRAM select nothing
   function automatic logic [4:0] cs_dec(input logic [2:0] cs);
      return {cs == CS_OBJ, cs == CS_CHA, cs == CS_V2, cs == CS_V1, cs == CS_VZ};
   endfunction

   assign tick        = ~i_EMU_CLK9MPCEN_n;
   assign accept      = i_CMD_VALID && state == IDLE;
   assign o_CPU_ADDR  = addr_q;
   assign o_RSP_VALID = valid_q;
   assign o_RSP_RDATA = rdata_q;
   assign o_RSP_ERR   = err_q;

`ifdef BUBSYS_CPUBUS_TIMEOUT_EN
   localparam int            CW       = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_TICKS - 1);
   logic [CW-1:0] cnt;
   // count DTACK-less ticks in WAIT, restarting each time WAIT is entered
   always_ff @(posedge i_EMU_MCLK or posedge i_EMU_MRST)
      if (i_EMU_MRST) cnt <= '0;
      else if (tick) cnt <= state == STRB ? '0 : (state == WAIT && i_DTACK_n) ? cnt + 1'b1 : cnt;
   assign timeout = i_DTACK_n && cnt == CNT_LAST;
`else
   assign timeout = 1'b0;
`endif

   // state register
   always_ff @(posedge i_EMU_MCLK or posedge i_EMU_MRST)
      if (i_EMU_MRST) state <= IDLE;
      else state <= state_nx;

   // next state: accept on any edge, every other step only on a tick
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = i_CMD_VALID ? ADDR : IDLE;
         ADDR:    if (tick) state_nx = STRB;
         STRB:    if (tick) state_nx = WAIT;
         WAIT:    if (tick) state_nx = !i_DTACK_n ? LATCH : timeout ? END : WAIT;
         LATCH:   if (tick) state_nx = END;
         END:     if (tick) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // bus outputs decoded from state so reset releases them immediately
   always_comb begin
      act         = state inside {ADDR, STRB, WAIT, LATCH};
      strb        = state inside {STRB, WAIT, LATCH};
      o_CMD_READY = state == IDLE;
      o_CPU_RW    = act ? rw_q : 1'b1;
      o_CPU_DOUT  = (act && !rw_q) ? wdata_q : IDLE_DOUT;
      o_CPU_UDS_n = ~(strb & be_q[1]);
      o_CPU_LDS_n = ~(strb & be_q[0]);
      {o_OBJRAM_n, o_CHACS_n, o_VCS2_n, o_VCS1_n, o_VZCS_n} = ~(strb ? cs_dec(cs_q) : 5'b0);
   end

   // command latch, read capture and response pulse
   always_ff @(posedge i_EMU_MCLK or posedge i_EMU_MRST)
      if (i_EMU_MRST) begin
         rw_q    <= 1'b1;
         addr_q  <= '0;
         wdata_q <= IDLE_DOUT;
         be_q    <= 2'b11;
         cs_q    <= 3'd7;
         rdata_q <= 16'hFFFF;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= tick && state == END;
         if (accept) begin
            rw_q    <= i_CMD_RW;
            addr_q  <= i_CMD_ADDR;
            wdata_q <= i_CMD_WDATA;
            be_q    <= i_CMD_BE == 2'b00 ? 2'b11 : i_CMD_BE;
            cs_q    <= i_CMD_CS;
            err_q   <= 1'b0;
         end
         if (tick && state == LATCH && rw_q) rdata_q <= i_CPU_DIN;
         if (tick && state == WAIT && timeout) begin
            err_q   <= 1'b1;
            rdata_q <= 16'hFFFF;
         end
      end
endmodule

// File: doc/bubsys_cpubus_initiator.md
Name: bubsys_cpubus_initiator

Overview:
- Synthesizable 68000-style bus-cycle initiator that drives the video board's CPU-side slave interface (address, data, RW, UDS/LDS, the five chip selects).
- Replaces the constant tie-offs used when the video block runs without a CPU; serves as a bench/bring-up master ahead of the real CPU core.
- Accepts one command per valid/ready handshake, runs one bus cycle paced by the 9 MHz clock enable, and returns read data or a completion/error response.

Parameters:
- TIMEOUT_TICKS, 32: number of 9 MHz ticks spent in WAIT before the cycle is aborted; only used with the optional feature.
- IDLE_DOUT, 16'hFFFF: value driven on o_CPU_DOUT when no write cycle is active.

Ports:
- i_EMU_MCLK  in  1  master clock; the only clock.
- i_EMU_MRST  in  1  asynchronous reset, active-high.
- i_EMU_CLK9MPCEN_n  in  1  active-low 9 MHz clock enable; the FSM advances only on MCLK edges where this is 0 (a "tick").
- i_CMD_VALID  in  1  command request.
- o_CMD_READY  out  1  high only in IDLE.
- i_CMD_RW  in  1  1 = read, 0 = write.
- i_CMD_ADDR  in  15  word address.
- i_CMD_WDATA  in  16  write data.
- i_CMD_BE  in  2  byte enables: [1] = upper, [0] = lower; 2'b00 is treated as 2'b11.
- i_CMD_CS  in  3  target: 0 = VZCS, 1 = VCS1, 2 = VCS2, 3 = CHACS, 4 = OBJRAM; 5-7 select no chip.
- o_CPU_ADDR  out  15;  o_CPU_DOUT  out  16;  o_CPU_RW  out  1;  o_CPU_UDS_n  out  1;  o_CPU_LDS_n  out  1.
- o_VZCS_n, o_VCS1_n, o_VCS2_n, o_CHACS_n, o_OBJRAM_n  out  1 each.
- i_CPU_DIN  in  16  slave read data.
- i_DTACK_n  in  1  slave acknowledge; tie 0 for zero-wait slaves.
- o_RSP_VALID  out  1  one-MCLK pulse at cycle end.
- o_RSP_RDATA  out  16  captured read data; holds until the next response.
- o_RSP_ERR  out  1  timeout flag, qualified by o_RSP_VALID.

Behaviour:
- Reset values (asynchronous, i_EMU_MRST = 1):
  - state = IDLE, o_CMD_READY = 1.
  - o_CPU_ADDR = 0, o_CPU_DOUT = IDLE_DOUT, o_CPU_RW = 1.
  - All strobes and chip selects = 1.
  - o_RSP_VALID = 0, o_RSP_RDATA = 16'hFFFF, o_RSP_ERR = 0.
- Accept: i_CMD_VALID & o_CMD_READY on any MCLK edge, independent of the tick.
  - Command fields are latched into internal registers.
  - The next state is ADDR; o_CMD_READY drops on the following cycle.
- States; each transition happens only on a tick:
  - ADDR: drive o_CPU_ADDR and o_CPU_RW. For a write, also drive o_CPU_DOUT = WDATA. -> STRB.
  - STRB: assert UDS_n/LDS_n per BE and the selected CS_n. -> WAIT.
  - WAIT: sample i_DTACK_n. If 0 -> LATCH; otherwise stay.
  - LATCH: on a read, capture i_CPU_DIN into o_RSP_RDATA on this tick. -> END.
  - END: negate strobes and CS_n; set o_CPU_RW = 1 and o_CPU_DOUT = IDLE_DOUT; pulse o_RSP_VALID for exactly one MCLK cycle. -> IDLE.
- Latency: at least 5 ticks from the first tick after accept to the response (zero-wait slave). Each additional DTACK_n-high tick adds one tick.
- Addressing and writes:
  - o_CPU_ADDR holds its last value in IDLE.
  - A write leaves o_RSP_RDATA unchanged.
- CS index 5-7: no CS_n asserts, but strobes still assert and the cycle completes via DTACK normally.
- At most one CS_n is low at any time; no CS_n is low outside the STRB..LATCH window.
- Reset mid-cycle: all strobes and chip selects release asynchronously and no response is issued.
- A command presented while busy is not accepted (READY = 0); the command must be held.

Optional Feature:
- Macro: BUBSYS_CPUBUS_TIMEOUT_EN.
- Defined:
  - A tick counter runs in WAIT.
  - After TIMEOUT_TICKS ticks with DTACK_n high -> END with o_RSP_ERR = 1 and o_RSP_RDATA = 16'hFFFF, for reads and writes alike.
  - The counter clears on entry to WAIT.
- Undefined: WAIT is unbounded and o_RSP_ERR is constant 0.

Decomposition:
- Package bubsys_cpubus_pkg holds:
  - the FSM state enum (IDLE, ADDR, STRB, WAIT, LATCH, END);
  - CS index constants (CS_VZ = 0 … CS_OBJ = 4);
  - the default IDLE_DOUT.
- No sub-module; the CS one-hot decode is an in-module function.

Test Plan:
- Read, zero wait: CS = 4, ADDR = 15'h1234, BE = 11, DTACK_n = 0, slave DIN = 16'hBEEF -> OBJRAM_n low for 3 ticks, RSP_VALID 5 ticks after accept, RDATA = BEEF, ERR = 0.
- Write, upper byte only: CS = 3, BE = 10, WDATA = 16'hA55A -> UDS_n low, LDS_n high; DOUT = A55A from ADDR through LATCH, then FFFF; RW = 0 during the cycle; RDATA unchanged.
- Wait states: DTACK_n held high for 3 ticks -> response at tick 8; CS_n held low throughout WAIT.
- Back-to-back commands with VALID held high -> second accept on the first MCLK edge after return to IDLE; no overlap of CS_n.
- Async reset asserted mid-WAIT -> strobes and CS_n go high in the same cycle, no RSP_VALID, READY = 1 after release.
- With BUBSYS_CPUBUS_TIMEOUT_EN, TIMEOUT_TICKS = 4, DTACK_n stuck high -> response after 4 WAIT ticks, ERR = 1, RDATA = FFFF.
